imem_loader: RTL and testbench

Sequential writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction memory's word-indexed write port from address 0 upward. It holds the core in reset while loading so the fetch side never reads a partially written program. It sits between the host byte link (UART receiver or testbench) and the instruction memory.

---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_word_assembler.sv | 36 +++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and the
// default memory geometry also used by the instruction memory itself.
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH  = 257;
    localparam int DEFAULT_ADDR_W = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit word; the first
// byte ends up in bits [7:0].
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_complete,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [31:0] shreg;

    // Each new byte enters at the top and older bytes move down, so after
    // four shifts byte 0 sits in the LSB lane.
    assign word          = {byte_in, shreg[31:8]};
    assign word_complete = byte_en && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            shreg    <= 32'd0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory word by word from index 0 and
// keeps the core held in reset until the whole program is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] LOAD_LEN,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [31:0]       WDATA,
    output logic              CPU_HOLD,
    output logic              LOAD_DONE,
    output logic              LEN_ERR,
    output logic [1:0]        DBG_STATE
);

    // One bit wider than the index so DEPTH = 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              len_err_q;

    logic              start_ok;
    logic              start_bad;
    logic              byte_en;
    logic              is_last;
    logic              asm_clear;
    logic              word_complete;
    logic [31:0]       asm_word;

    assign start_ok  = (state == ST_IDLE) && START && (LOAD_LEN != '0)
                       && ({1'b0, LOAD_LEN} <= DEPTH_C);
    assign start_bad = (state == ST_IDLE) && START && !start_ok;

    // Handshake: a byte transfers on every rising edge where BYTE_VALID and
    // BYTE_READY are both high; BYTE_READY depends only on state, never on VALID.
    assign byte_en   = (state == ST_RECV) && BYTE_VALID;
    assign is_last   = (idx == last_idx);
    assign asm_clear = start_ok || ((state == ST_WRITE) && !is_last);

    word_assembler u_word_assembler (
        .clk           (CLK),
        .reset         (RESET),
        .clear         (asm_clear),
        .byte_en       (byte_en),
        .byte_in       (BYTE_IN),
        .word_complete (word_complete),
        .word          (asm_word)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            idx       <= '0;
            last_idx  <= '0;
            waddr_q   <= '0;
            wdata_q   <= 32'd0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= start_bad;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        last_idx <= LOAD_LEN - ADDR_W'(1);
                        idx      <= '0;
                        state    <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    // Write port registers are loaded only here so they hold
                    // steady through the next word's byte collection.
                    if (word_complete) begin
                        waddr_q <= idx;
                        wdata_q <= asm_word;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (is_last) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= ST_RECV;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BYTE_READY = (state == ST_RECV);
    assign WE         = (state == ST_WRITE);
    assign CPU_HOLD   = (state == ST_RECV) || (state == ST_WRITE);
    assign LOAD_DONE  = (state == ST_DONE);
    assign LEN_ERR    = len_err_q;
    assign WADDR      = waddr_q;
    assign WDATA      = wdata_q;
    assign DBG_STATE  = state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-request table plus directed
// multi-cycle load sequences, with a write scoreboard.
module tb_imem_loader;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [8:0] LOAD_LEN;
    logic [7:0] BYTE_IN;
    logic       BYTE_VALID;
    logic       BYTE_READY;
    logic       WE;
    logic [8:0] WADDR;
    logic [31:0] WDATA;
    logic       CPU_HOLD;
    logic       LOAD_DONE;
    logic       LEN_ERR;
    logic [1:0] DBG_STATE;

    always #5 CLK = ~CLK;

    imem_loader #(.DEPTH(257), .ADDR_W(9)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .LOAD_LEN   (LOAD_LEN),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .WE         (WE),
        .WADDR      (WADDR),
        .WDATA      (WDATA),
        .CPU_HOLD   (CPU_HOLD),
        .LOAD_DONE  (LOAD_DONE),
        .LEN_ERR    (LEN_ERR),
        .DBG_STATE  (DBG_STATE)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int we_cnt    = 0;
    int done_cnt  = 0;

    logic [40:0] exp_q[$];
    logic [40:0] exp_e;

    typedef struct {
        logic [8:0] len;
        logic       exp_err;
        logic       exp_hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Write monitor: every WE must match the oldest expected {addr, data}.
    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_we: got addr %h data %h expected no write", WADDR, WDATA);
            end else begin
                exp_e = exp_q.pop_front();
                check("waddr", 32'(WADDR), 32'(exp_e[40:32]));
                check("wdata", WDATA, exp_e[31:0]);
                check("hold_in_write", 32'(CPU_HOLD), 32'd1);
            end
        end
        if (LOAD_DONE === 1'b1) done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [8:0] len);
        START    = 1'b1;
        LOAD_LEN = len;
        tick();
        START    = 1'b0;
        LOAD_LEN = 9'(32'($urandom_range(0, 511)));
    endtask

    // Called just after a rising edge; holds VALID until the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got        = 1'b0;
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (BYTE_READY === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL byte_accept_timeout: got ready 0 expected 1");
        end
        @(posedge CLK);
        #1;
        BYTE_VALID = 1'b0;
        BYTE_IN    = 8'(32'($urandom_range(0, 255)));
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [8:0] addr, input logic [31:0] w, input int gap);
        for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8], gap);
        send_byte(w[31:24], 0);
        exp_q.push_back({addr, w});
    endtask

    task automatic expect_done();
        @(negedge CLK);
        check("we_final", 32'(WE), 32'd1);
        @(negedge CLK);
        check("load_done", 32'(LOAD_DONE), 32'd1);
        check("hold_at_done", 32'(CPU_HOLD), 32'd0);
        @(negedge CLK);
        check("done_one_cycle", 32'(LOAD_DONE), 32'd0);
        check("idle_after_done", 32'(DBG_STATE), 32'd0);
        tick();
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{len: 9'd0,   exp_err: 1'b1, exp_hold: 1'b0};
        vecs[1] = '{len: 9'd258, exp_err: 1'b1, exp_hold: 1'b0};
        vecs[2] = '{len: 9'd511, exp_err: 1'b1, exp_hold: 1'b0};
        vecs[3] = '{len: 9'd1,   exp_err: 1'b0, exp_hold: 1'b1};
        vecs[4] = '{len: 9'd257, exp_err: 1'b0, exp_hold: 1'b1};
        vecs[5] = '{len: 9'd256, exp_err: 1'b0, exp_hold: 1'b1};

        RESET      = 1'b1;
        START      = 1'b0;
        LOAD_LEN   = 9'd0;
        BYTE_IN    = 8'd0;
        BYTE_VALID = 1'b0;

        // Reset values
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_byte_ready", 32'(BYTE_READY), 32'd0);
        check("rst_we", 32'(WE), 32'd0);
        check("rst_hold", 32'(CPU_HOLD), 32'd0);
        check("rst_done", 32'(LOAD_DONE), 32'd0);
        check("rst_len_err", 32'(LEN_ERR), 32'd0);
        check("rst_waddr", 32'(WADDR), 32'd0);
        check("rst_wdata", WDATA, 32'd0);
        check("rst_state", 32'(DBG_STATE), 32'd0);
        tick();
        RESET = 1'b0;
        tick();

        // Start-request table: rejected lengths pulse LEN_ERR, accepted ones
        // raise hold/ready and are then aborted by reset.
        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].len);
            @(negedge CLK);
            check("tbl_len_err", 32'(LEN_ERR), 32'(vecs[i].exp_err));
            check("tbl_hold", 32'(CPU_HOLD), 32'(vecs[i].exp_hold));
            check("tbl_ready", 32'(BYTE_READY), 32'(vecs[i].exp_hold));
            @(negedge CLK);
            check("tbl_err_pulse", 32'(LEN_ERR), 32'd0);
            check("tbl_hold_2", 32'(CPU_HOLD), 32'(vecs[i].exp_hold));
            if (vecs[i].exp_hold) begin
                tick();
                RESET = 1'b1;
                tick();
                RESET = 1'b0;
                @(negedge CLK);
                check("tbl_abort_hold", 32'(CPU_HOLD), 32'd0);
                check("tbl_abort_state", 32'(DBG_STATE), 32'd0);
            end
            tick();
        end

        // RESET wins over START in the same cycle
        RESET    = 1'b1;
        START    = 1'b1;
        LOAD_LEN = 9'd1;
        tick();
        RESET = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        check("rst_prio_hold", 32'(CPU_HOLD), 32'd0);
        check("rst_prio_state", 32'(DBG_STATE), 32'd0);
        tick();

        // Two-word load, back-to-back bytes
        do_start(9'd2);
        send_word(9'd0, 32'hfe010113, 0);
        send_word(9'd1, 32'h02010413, 0);
        expect_done();

        // Stalled stream: 3 idle cycles between every byte
        do_start(9'd2);
        send_word(9'd0, 32'hfe010113, 3);
        repeat (3) tick();
        send_word(9'd1, 32'h02010413, 3);
        expect_done();

        // Reset after two bytes of word 0, then a fresh one-word load
        do_start(9'd2);
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check("midrst_hold", 32'(CPU_HOLD), 32'd0);
        check("midrst_state", 32'(DBG_STATE), 32'd0);
        check("midrst_we", 32'(WE), 32'd0);
        tick();
        do_start(9'd1);
        send_word(9'd0, 32'ha9470793, 0);
        expect_done();

        // START during RECV is ignored
        do_start(9'd2);
        send_byte(8'hef, 0);
        send_byte(8'hbe, 0);
        do_start(9'd5);
        @(negedge CLK);
        check("restart_no_err", 32'(LEN_ERR), 32'd0);
        check("restart_state", 32'(DBG_STATE), 32'd1);
        tick();
        send_byte(8'had, 0);
        send_byte(8'hde, 0);
        exp_q.push_back({9'd0, 32'hdeadbeef});
        send_word(9'd1, 32'h12345678, 0);
        expect_done();

        // Full depth with random words
        do_start(9'd257);
        for (int i = 0; i < 257; i++) send_word(9'(i), $urandom, 0);
        expect_done();

        repeat (4) tick();
        check("we_total", 32'(we_cnt), 32'd264);
        check("done_total", 32'(done_cnt), 32'd5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
